// File: rtl/fir_error_gen_if.sv
// Handshake/data bundle between the LMS forward path and its neighbours.
// Master drives the sample/desired/weights side; slave is the filter.
interface fir_error_gen_if #(
    parameter int WIDTH = 16,
    parameter int TAPS  = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        x_in;
    logic [WIDTH-1:0]        d_in;
    logic [WIDTH-1:0]        mu;
    logic [TAPS*WIDTH-1:0]   weights_flat;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        y_out;
    logic [WIDTH-1:0]        error_out;
    logic [WIDTH-1:0]        mu_error_out;
    logic [TAPS*WIDTH-1:0]   taps_flat;

    modport master (
        output in_valid, x_in, d_in, mu, weights_flat, out_ready,
        input  in_ready, out_valid, y_out, error_out, mu_error_out, taps_flat
    );
    modport slave (
        input  in_valid, x_in, d_in, mu, weights_flat, out_ready,
        output in_ready, out_valid, y_out, error_out, mu_error_out, taps_flat
    );
endinterface

// File: rtl/fir_error_gen.sv
// LMS forward path: tap delay line, one time-multiplexed MAC, error and mu*error.
// Define FIR_ERR_SAT_EN to saturate y, error and mu_error instead of wrapping.
module fir_error_gen #(
    parameter int WIDTH = 16,
    parameter int QP    = 12,
    parameter int TAPS  = 8
) (
    input  logic          clk,
    input  logic          reset,
    fir_error_gen_if.slave bus
);
    localparam int KW   = $clog2(TAPS);
    localparam int AW   = 2*WIDTH + KW;
    localparam int AW1  = AW + 1;
    localparam int MW1  = 2*WIDTH + 1;
    localparam int HALF = 1 << (QP-1);

    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, ERR, OUT} state_t;

    state_t                       state;
    logic [TAPS-1:0][WIDTH-1:0]   taps, w_lat;
    logic [WIDTH-1:0]             mu_lat, d_lat;
    logic signed [AW-1:0]         acc;
    logic [KW-1:0]                k;

    logic signed [2*WIDTH-1:0]    prod, mprod;
    logic signed [AW:0]           rnd_acc;
    logic signed [2*WIDTH:0]      rnd_mu;
    logic [WIDTH:0]               diff;
    logic [WIDTH-1:0]             y_nxt, err_nxt, mue_nxt;

    assign prod    = $signed(w_lat[k]) * $signed(taps[k]);
    assign mprod   = $signed(mu_lat) * $signed(bus.error_out);
    assign rnd_acc = AW1'(acc) + AW1'(HALF);
    assign rnd_mu  = MW1'(mprod) + MW1'(HALF);
    assign diff    = {d_lat[WIDTH-1], d_lat} - {y_nxt[WIDTH-1], y_nxt};

    // Rounded values fit in WIDTH only if every bit above the result sign agrees.
    always_comb begin
        y_nxt   = rnd_acc[QP +: WIDTH];
        err_nxt = diff[WIDTH-1:0];
        mue_nxt = rnd_mu[QP +: WIDTH];
`ifdef FIR_ERR_SAT_EN
        if (!(&rnd_acc[AW:QP+WIDTH-1] || ~|rnd_acc[AW:QP+WIDTH-1]))
            y_nxt = rnd_acc[AW] ? MINV : MAXV;
        if (diff[WIDTH] != diff[WIDTH-1])
            err_nxt = diff[WIDTH] ? MINV : MAXV;
        if (!(&rnd_mu[2*WIDTH:QP+WIDTH-1] || ~|rnd_mu[2*WIDTH:QP+WIDTH-1]))
            mue_nxt = rnd_mu[2*WIDTH] ? MINV : MAXV;
`endif
    end

    assign bus.taps_flat = taps;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            taps             <= '0;
            w_lat            <= '0;
            mu_lat           <= '0;
            d_lat            <= '0;
            acc              <= '0;
            k                <= '0;
            bus.in_ready     <= 1'b1;
            bus.out_valid    <= 1'b0;
            bus.y_out        <= '0;
            bus.error_out    <= '0;
            bus.mu_error_out <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid && bus.in_ready) begin
                    taps         <= {taps[TAPS-2:0], bus.x_in};
                    w_lat        <= bus.weights_flat;
                    mu_lat       <= bus.mu;
                    d_lat        <= bus.d_in;
                    acc          <= '0;
                    k            <= '0;
                    bus.in_ready <= 1'b0;
                    state        <= MAC;
                end
                MAC: begin
                    acc <= acc + AW'(prod);
                    k   <= k + 1'b1;
                    if (k == KW'(TAPS-1)) state <= ERR;
                end
                ERR: begin
                    bus.y_out     <= y_nxt;
                    bus.error_out <= err_nxt;
                    state         <= OUT;
                end
                OUT: begin
                    // First OUT cycle produces mu_error; afterwards wait for the consumer.
                    if (!bus.out_valid) begin
                        bus.mu_error_out <= mue_nxt;
                        bus.out_valid    <= 1'b1;
                    end else if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
